mem_arbiter: RTL

- Shares one variable-latency memory port between two requesters: the instruction fetch unit (IFU) and the load/store path of the execute stage (LSU).
- Accepts one request at a time, issues it to memory with a valid/ready handshake, and waits for the response. Returns the response to the owning requester as a one-cycle pulse.
- Sits between IFU/EXU and the single data/instruction memory model. It replaces the direct combinational memory hookup.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single valid/ready memory port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN to replace fixed LSU priority with alternating grants.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [DATA_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [DATA_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic   ifu_acc, lsu_acc, resp_take;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;
    logic lsu_wins, ifu_wins;
    assign lsu_wins = !ifu_req_valid || !last_grant;
    assign ifu_wins = !lsu_req_valid ||  last_grant;
`else
    logic lsu_wins, ifu_wins;
    assign lsu_wins = 1'b1;
    assign ifu_wins = !lsu_req_valid;
`endif

    assign ifu_acc = ifu_req_valid && ifu_req_ready;
    assign lsu_acc = lsu_req_valid && lsu_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        resp_take      = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                lsu_req_ready = lsu_wins;
                ifu_req_ready = ifu_wins;
                if ((lsu_req_valid && lsu_wins) || (ifu_req_valid && ifu_wins))
                    state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // Same-cycle response skips WAIT entirely
                    resp_take = mem_resp_valid;
                    state_nxt = mem_resp_valid ? RESP : WAIT;
                end
            end
            WAIT: begin
                resp_take = mem_resp_valid;
                if (mem_resp_valid) state_nxt = RESP;
            end
            RESP: begin
                ifu_resp_valid = !owner;
                lsu_resp_valid = owner;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            if (lsu_acc) begin
                owner     <= 1'b1;
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wen ? lsu_wdata : '0;
                mem_wmask <= lsu_wen ? lsu_wmask : '0;
            end else if (ifu_acc) begin
                owner     <= 1'b0;
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end
            if (resp_take) begin
                if (owner) lsu_rdata <= mem_rdata;
                else       ifu_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last_grant <= 1'b0;
        else if (lsu_acc) last_grant <= 1'b1;
        else if (ifu_acc) last_grant <= 1'b0;
    end
`endif

endmodule
